// File: rtl/clkdiv_ramp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : clkdiv_ramp_pkg
// Brief    : State encoding and ratio-step helper for the divider ramp
// Revision : 1.0 - initial release
// ============================================================================
package clkdiv_ramp_pkg;

    // Widest ratio the helper supports; one guard bit is added on top.
    localparam int c_maxw = 16;

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_step  = 3'd1;
    localparam logic [2:0] c_st_wack  = 3'd2;
    localparam logic [2:0] c_st_wrel  = 3'd3;
    localparam logic [2:0] c_st_dwell = 3'd4;

    // One bounded move towards tgt; the guard bit keeps cur+step from wrapping.
    function automatic logic [c_maxw:0] next_div(
        input logic [c_maxw:0] cur,
        input logic [c_maxw:0] tgt,
        input logic [c_maxw:0] step
    );
        logic [c_maxw:0] sum;
        logic [c_maxw:0] dif;
        sum      = cur + step;
        dif      = cur - tgt;
        next_div = cur;
        if (cur < tgt) begin
            next_div = (sum > tgt) ? tgt : sum;
        end else if (cur > tgt) begin
            next_div = (dif > step) ? (cur - step) : tgt;
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/clkdiv_ramp_tmr.sv
`default_nettype none
// ============================================================================
// Module   : clkdiv_ramp_tmr
// Brief    : Loadable down-counter with zero flag (dwell and watchdog share it)
// Revision : 1.0 - initial release
// ============================================================================
module clkdiv_ramp_tmr #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_value,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_value;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/clkdiv_ramp.sv
`default_nettype none
// ============================================================================
// Module   : clkdiv_ramp
// Brief    : Walks the clock-divider ratio to a target in bounded, handshaken steps
// Revision : 1.0 - initial release
// ============================================================================
module clkdiv_ramp
    import clkdiv_ramp_pkg::*;
#(
    parameter int N       = 4,
    parameter int STEP    = 1,
    parameter int DW      = 8,
    parameter int RST_DIV = 0,
    parameter int TMO     = (1 << N) + 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  target,
    input  logic          load,
    input  logic [DW-1:0] dwell,
    input  logic          dack,
    output logic [N-1:0]  div,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam int              c_tw      = (DW > $clog2(TMO) + 1) ? DW : $clog2(TMO) + 1;
    localparam logic [c_tw-1:0] c_tmo     = c_tw'(TMO);
    localparam logic [c_maxw:0] c_step    = (c_maxw + 1)'(STEP);
    localparam logic [N-1:0]    c_rst_div = N'(RST_DIV);

    logic [2:0]      r_state;
    logic [N-1:0]    r_tgt;
    logic [DW-1:0]   r_dwell;

    logic [2:0]      w_state_nxt;
    logic [N-1:0]    w_div_nxt;
    logic [N-1:0]    w_tgt_nxt;
    logic [DW-1:0]   w_dwell_nxt;
    logic            w_busy_nxt;
    logic            w_done_nxt;
    logic            w_err_nxt;
    logic            w_tmr_load;
    logic [c_tw-1:0] w_tmr_val;
    logic            w_tmr_zero;
    logic [N-1:0]    w_step_div;
    logic [DW-1:0]   w_dwell_m1;

    assign w_step_div = N'(next_div((c_maxw + 1)'(div), (c_maxw + 1)'(r_tgt), c_step));
    // Counter is preloaded with dwell-1 so a dwell of d holds max(d,1) cycles.
    assign w_dwell_m1 = (r_dwell == '0) ? '0 : (r_dwell - DW'(1));

    clkdiv_ramp_tmr #(
        .W (c_tw)
    ) u_tmr (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_tmr_load),
        .i_value (w_tmr_val),
        .o_zero  (w_tmr_zero)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
            r_tgt   <= c_rst_div;
            r_dwell <= '0;
            div     <= c_rst_div;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_tgt   <= w_tgt_nxt;
            r_dwell <= w_dwell_nxt;
            div     <= w_div_nxt;
            busy    <= w_busy_nxt;
            done    <= w_done_nxt;
            err     <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_div_nxt   = div;
        w_tgt_nxt   = r_tgt;
        w_dwell_nxt = r_dwell;
        w_busy_nxt  = busy;
        w_done_nxt  = 1'b0;
        w_err_nxt   = err;
        w_tmr_load  = 1'b0;
        w_tmr_val   = '0;

        // A load retargets at any time; the step in flight still finishes.
        if (load) begin
            w_tgt_nxt   = target;
            w_dwell_nxt = dwell;
            w_err_nxt   = 1'b0;
        end

        case (r_state)
            c_st_idle: begin
                if (load) begin
                    if (target == div) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_state_nxt = c_st_step;
                        w_busy_nxt  = 1'b1;
                    end
                end
            end
            c_st_step: begin
                w_div_nxt   = w_step_div;
                w_state_nxt = c_st_wack;
                w_tmr_load  = 1'b1;
                w_tmr_val   = c_tmo;
            end
            c_st_wack: begin
                if (dack) begin
                    w_state_nxt = c_st_wrel;
                    w_tmr_load  = 1'b1;
                    w_tmr_val   = c_tmo;
                end else if (w_tmr_zero) begin
                    w_state_nxt = c_st_idle;
                    w_busy_nxt  = 1'b0;
                    w_err_nxt   = 1'b1;
                end
            end
            c_st_wrel: begin
                if (!dack) begin
                    w_state_nxt = c_st_dwell;
                    w_tmr_load  = 1'b1;
                    w_tmr_val   = c_tw'(w_dwell_m1);
                end else if (w_tmr_zero) begin
                    w_state_nxt = c_st_idle;
                    w_busy_nxt  = 1'b0;
                    w_err_nxt   = 1'b1;
                end
            end
            c_st_dwell: begin
                if (w_tmr_zero) begin
                    if (div == r_tgt) begin
                        w_state_nxt = c_st_idle;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = c_st_step;
                    end
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_clkdiv_ramp.sv
`default_nettype none
// ============================================================================
// Module   : tb_clkdiv_ramp
// Brief    : Scoreboard bench for clkdiv_ramp with a behavioural divider handshake
// Revision : 1.0 - initial release
// ============================================================================
module tb_clkdiv_ramp;

    localparam int N = 4, STEP = 3, DW = 8, RST_DIV = 0, TMO = 20;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  target = '0;
    logic          load = 1'b0;
    logic [DW-1:0] dwell = '0;
    logic          dack = 1'b0;
    logic [N-1:0]  div;
    logic          busy, done, err;

    clkdiv_ramp #(.N(N), .STEP(STEP), .DW(DW), .RST_DIV(RST_DIV), .TMO(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .target(target), .load(load), .dwell(dwell),
        .dack(dack), .div(div), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad = 0;
    int         done_cnt = 0;
    int         hs_cnt = 0;
    logic [N-1:0] prev_div = N'(RST_DIV);
    logic       prev_dack = 1'b0;
    bit         hs_en = 1'b1;
    int         m_div = RST_DIV;
    logic [N-1:0] exp_q[$];

    // Divider stand-in: each ratio change is answered by a 3-cycle dack pulse.
    initial begin : hs_model
        logic [N-1:0] last;
        last = N'(RST_DIV);
        forever begin
            @(negedge clk);
            if (div !== last) begin
                last = div;
                if (hs_en) begin
                    repeat (2) @(negedge clk);
                    dack = 1'b1;
                    repeat (3) @(negedge clk);
                    dack = 1'b0;
                end
            end
        end
    end

    initial begin : guard
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    // Every observed ratio change must match the head of the expected queue.
    task automatic tick();
        logic [N-1:0] e;
        @(negedge clk);
        #1;
        if (div !== prev_div) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL div_step: got %0d, no change expected", div);
            end else begin
                e = exp_q.pop_front();
                if (div !== e) begin
                    bad++;
                    $display("FAIL div_step: got %0d expected %0d", div, e);
                end
            end
            prev_div = div;
        end
        if (done === 1'b1) done_cnt++;
        if (dack && !prev_dack) hs_cnt++;
        prev_dack = dack;
    endtask

    task automatic push_model(input int from, input int to);
        int cur;
        cur = from;
        while (cur != to) begin
            if (cur < to) cur = (to - cur > STEP) ? cur + STEP : to;
            else          cur = (cur - to > STEP) ? cur - STEP : to;
            exp_q.push_back(N'(cur));
        end
    endtask

    task automatic drive_load(input int t, input int d);
        target = N'(t);
        dwell  = DW'(d);
        load   = 1'b1;
        tick();
        load   = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        int start;
        start = done_cnt;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (done_cnt != start) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        total++;
        if (div !== N'(RST_DIV) || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: div=%0d busy=%b done=%b err=%b expected div=%0d busy=0 done=0 err=0",
                     div, busy, done, err, RST_DIV);
        end
        rst_n = 1'b1;
        repeat (8) tick();
        m_div = RST_DIV;
    endtask

    task automatic test_ramp_up();
        bit ok;
        int d0, h0;
        d0 = done_cnt;
        h0 = hs_cnt;
        push_model(m_div, 8);
        drive_load(8, 2);
        total++;
        if (div !== 4'd0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL up_latch: div=%0d busy=%b expected div=0 busy=1", div, busy);
        end
        tick();
        total++;
        if (div !== 4'd3) begin
            bad++;
            $display("FAIL up_first_step: div=%0d expected 3", div);
        end
        wait_done(300, ok);
        total++;
        if (!ok || busy !== 1'b0) begin
            bad++;
            $display("FAIL up_done: done_seen=%0d busy=%b expected done_seen=1 busy=0", ok, busy);
        end
        repeat (5) tick();
        total++;
        if (div !== 4'd8 || exp_q.size() != 0 || done_cnt - d0 != 1 || hs_cnt - h0 != 3) begin
            bad++;
            $display("FAIL up_final: div=%0d left=%0d dones=%0d hs=%0d expected div=8 left=0 dones=1 hs=3",
                     div, exp_q.size(), done_cnt - d0, hs_cnt - h0);
        end
        m_div = 8;
    endtask

    task automatic test_equal();
        bit ok;
        push_model(m_div, 5);
        drive_load(5, 0);
        wait_done(300, ok);
        repeat (3) tick();
        total++;
        if (!ok || div !== 4'd5) begin
            bad++;
            $display("FAIL eq_setup: done_seen=%0d div=%0d expected done_seen=1 div=5", ok, div);
        end
        drive_load(5, 0);
        total++;
        if (done !== 1'b1 || busy !== 1'b0 || div !== 4'd5) begin
            bad++;
            $display("FAIL eq_done: done=%b busy=%b div=%0d expected done=1 busy=0 div=5", done, busy, div);
        end
        tick();
        total++;
        if (done !== 1'b0 || busy !== 1'b0 || div !== 4'd5) begin
            bad++;
            $display("FAIL eq_after: done=%b busy=%b div=%0d expected done=0 busy=0 div=5", done, busy, div);
        end
        m_div = 5;
    endtask

    task automatic test_ramp_down();
        bit ok;
        push_model(m_div, 15);
        drive_load(15, 0);
        wait_done(400, ok);
        total++;
        if (!ok || div !== 4'd15) begin
            bad++;
            $display("FAIL top_setup: done_seen=%0d div=%0d expected done_seen=1 div=15", ok, div);
        end
        push_model(15, 1);
        drive_load(1, 1);
        wait_done(400, ok);
        total++;
        if (!ok || div !== 4'd1 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL down_final: done_seen=%0d div=%0d left=%0d expected done_seen=1 div=1 left=0",
                     ok, div, exp_q.size());
        end
        push_model(1, 0);
        drive_load(0, 0);
        wait_done(200, ok);
        total++;
        if (!ok || div !== 4'd0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL zero_target: done_seen=%0d div=%0d busy=%b expected done_seen=1 div=0 busy=0",
                     ok, div, busy);
        end
        m_div = 0;
    endtask

    task automatic test_midload();
        bit ok;
        bit hit;
        int d0, h0;
        d0 = done_cnt;
        h0 = hs_cnt;
        push_model(m_div, 12);
        drive_load(12, 1);
        hit = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (div === 4'd6) begin
                hit = 1'b1;
                break;
            end
            tick();
        end
        total++;
        if (!hit) begin
            bad++;
            $display("FAIL mid_reach6: div=%0d expected to reach 6", div);
        end
        exp_q.delete();
        push_model(6, 1);
        drive_load(1, 1);
        total++;
        if (div !== 4'd6 || busy !== 1'b1) begin
            bad++;
            $display("FAIL mid_hold: div=%0d busy=%b expected div=6 busy=1", div, busy);
        end
        wait_done(400, ok);
        repeat (5) tick();
        total++;
        if (!ok || div !== 4'd1 || exp_q.size() != 0 || done_cnt - d0 != 1 || hs_cnt - h0 != 4) begin
            bad++;
            $display("FAIL mid_final: done_seen=%0d div=%0d left=%0d dones=%0d hs=%0d expected 1,1,0,1,4",
                     ok, div, exp_q.size(), done_cnt - d0, hs_cnt - h0);
        end
        m_div = 1;
    endtask

    task automatic test_timeout();
        int n, d0;
        bit hit;
        hs_en = 1'b0;
        d0 = done_cnt;
        push_model(m_div, 4);
        drive_load(9, 0);
        hit = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (div === 4'd4) begin
                hit = 1'b1;
                break;
            end
            tick();
        end
        n = 0;
        while (err !== 1'b1 && n < TMO + 10) begin
            tick();
            n++;
        end
        total++;
        if (!hit || err !== 1'b1 || n < TMO || n > TMO + 2) begin
            bad++;
            $display("FAIL tmo_err: step_seen=%0d err=%b cycles=%0d expected step_seen=1 err=1 cycles %0d..%0d",
                     hit, err, n, TMO, TMO + 2);
        end
        total++;
        if (busy !== 1'b0 || div !== 4'd4) begin
            bad++;
            $display("FAIL tmo_state: busy=%b div=%0d expected busy=0 div=4", busy, div);
        end
        repeat (6) tick();
        total++;
        if (err !== 1'b1 || div !== 4'd4 || done_cnt != d0) begin
            bad++;
            $display("FAIL tmo_hold: err=%b div=%0d dones=%0d expected err=1 div=4 dones=0",
                     err, div, done_cnt - d0);
        end
        hs_en = 1'b1;
        drive_load(4, 0);
        total++;
        if (err !== 1'b0 || done !== 1'b1) begin
            bad++;
            $display("FAIL tmo_clear: err=%b done=%b expected err=0 done=1", err, done);
        end
        tick();
        m_div = 4;
    endtask

    task automatic test_reset_midramp();
        bit hit;
        push_model(m_div, 15);
        drive_load(15, 0);
        hit = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (dack === 1'b1) begin
                hit = 1'b1;
                break;
            end
        end
        tick();
        total++;
        if (!hit || dack !== 1'b1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL rst_setup: dack_seen=%0d dack=%b busy=%b expected 1,1,1", hit, dack, busy);
        end
        exp_q.delete();
        exp_q.push_back(N'(RST_DIV));
        rst_n = 1'b0;
        tick();
        total++;
        if (div !== N'(RST_DIV) || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid: div=%0d busy=%b done=%b err=%b expected div=%0d busy=0 done=0 err=0",
                     div, busy, done, err, RST_DIV);
        end
        rst_n = 1'b1;
        repeat (10) tick();
        total++;
        if (div !== N'(RST_DIV) || busy !== 1'b0 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL rst_idle: div=%0d busy=%b left=%0d expected div=%0d busy=0 left=0",
                     div, busy, exp_q.size(), RST_DIV);
        end
    endtask

    initial begin
        test_reset();
        test_ramp_up();
        test_equal();
        test_ramp_down();
        test_midload();
        test_timeout();
        test_reset_midramp();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
